// File: rtl/insertar_ficha.sv
// insertar_ficha: writes a 2/4 tile into a pseudo-randomly chosen empty cell taken from the zero-finder list.
// Optional INSERTAR_FORZADO_EN adds forzar/indice_forzado to override the random pick deterministically.
module insertar_ficha #(
   parameter logic [15:0] SEMILLA    = 16'hACE1,
   parameter int          VALOR_BAJO = 2,
   parameter int          VALOR_ALTO = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
`ifdef INSERTAR_FORZADO_EN
   input  logic        forzar,
   input  logic [3:0]  indice_forzado,
`endif
   input  logic [31:0] matriz_entrada [4][4],
   input  logic [31:0] lista [16],
   input  logic [31:0] contador,
   output logic [31:0] matriz_salida [4][4],
   output logic [3:0]  posicion,
   output logic [31:0] valor,
   output logic        ocupado,
   output logic        done,
   output logic        lleno
);
   typedef enum logic [1:0] {IDLE, MODULO, ESCRIBIR, VACIO} estado_t;
   localparam logic [15:0] SEMILLA_OK = (SEMILLA == 16'h0) ? 16'h0001 : SEMILLA;
   estado_t     estado_q, estado_d;
   logic [15:0] lfsr_q;
   logic [31:0] tab_q [4][4];
   logic [31:0] lista_q [16];
   logic [31:0] sal_q [4][4];
   logic [4:0]  cnt_q, cnt_ini;
   logic [3:0]  r_q, r_ini, pos_q;
   logic        alto_q, alto_ini, vacio_in, valido, done_q, lleno_q;
   logic [31:0] valor_q, nuevo, p;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado_q <= IDLE;
         lfsr_q   <= SEMILLA_OK;
         pos_q    <= '0;
         valor_q  <= '0;
         done_q   <= 1'b0;
         lleno_q  <= 1'b0;
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
               sal_q[i][j] <= '0;
      end else begin
         estado_q <= estado_d;
         lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         done_q   <= estado_q == ESCRIBIR;
         if (estado_q == IDLE && start) begin
            tab_q   <= matriz_entrada;
            lista_q <= lista;
            cnt_q   <= cnt_ini;
            r_q     <= r_ini;
            alto_q  <= alto_ini;
         end
         if (estado_q == MODULO && {1'b0, r_q} >= cnt_q)
            r_q <= r_q - cnt_q[3:0];
         // the empty case reaches here via VACIO with cnt_q==0, so it never writes
         if (estado_q == ESCRIBIR) begin
            lleno_q <= !valido;
            sal_q   <= tab_q;
            if (valido) begin
               sal_q[p[3:2]][p[1:0]] <= nuevo;
               pos_q   <= p[3:0];
               valor_q <= nuevo;
            end
         end
      end
   end
   always_comb begin
      estado_d = (estado_q == IDLE)   ? (start ? (vacio_in ? VACIO : MODULO) : IDLE) :
                 (estado_q == MODULO) ? (({1'b0, r_q} >= cnt_q) ? MODULO : ESCRIBIR) :
                 (estado_q == VACIO)  ? ESCRIBIR : IDLE;
   end
   always_comb begin
      vacio_in = contador[31] || contador == 32'd0;
      cnt_ini  = vacio_in ? 5'd0 : (contador > 32'd16) ? 5'd16 : contador[4:0];
`ifdef INSERTAR_FORZADO_EN
      r_ini    = forzar ? indice_forzado : lfsr_q[3:0];
      alto_ini = !forzar && lfsr_q[7:4] == 4'd0;
`else
      r_ini    = lfsr_q[3:0];
      alto_ini = lfsr_q[7:4] == 4'd0;
`endif
      p             = lista_q[r_q];
      valido        = cnt_q != 5'd0 && p[31:4] == 28'd0;
      nuevo         = alto_q ? 32'(VALOR_ALTO) : 32'(VALOR_BAJO);
      matriz_salida = sal_q;
      posicion      = pos_q;
      valor         = valor_q;
      ocupado       = estado_q != IDLE;
      done          = done_q;
      lleno         = lleno_q;
   end
endmodule
